// File: rtl/axi_wr_sched.sv
`default_nettype none
// ============================================================================
// Module  : axi_wr_sched
// Brief   : Round-robin AW arbiter + single-outstanding AW/W/B phase scheduler
//           for two write masters and three slaves (S1, S2, SDEFAULT).
//           Optional watchdog enabled by defining AXI_WR_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module axi_wr_sched #(
  parameter logic [31:0] S1_BASE        = 32'h0000_0000,
  parameter logic [31:0] S2_BASE        = 32'h0001_0000,
  parameter int unsigned REGION_BITS    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        AWVALID_M0,
  input  logic [31:0] AWADDR_M0,
  input  logic        AWVALID_M1,
  input  logic [31:0] AWADDR_M1,
  input  logic        AW_HS,
  input  logic        W_LAST_HS,
  input  logic        B_HS,
  output logic [1:0]  GRANT,
  output logic [1:0]  MASTER_ID,
  output logic [2:0]  SLAVE_SEL,
  output logic        AW_EN,
  output logic        W_EN,
  output logic        B_EN,
  output logic        BUSY,
  output logic        TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;      // 0: M0 wins a tie, 1: M1 wins a tie
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  mid_q, mid_d;
  logic [2:0]  sel_q, sel_d;

  logic        pick_m1;
  logic [31:0] req_addr;
  logic [31-REGION_BITS:0] req_region;
  logic        unused_addr_low;

  assign pick_m1    = AWVALID_M1 & (~AWVALID_M0 | prio_q);
  assign req_addr   = pick_m1 ? AWADDR_M1 : AWADDR_M0;
  assign req_region = req_addr[31:REGION_BITS];
  assign unused_addr_low = ^req_addr[REGION_BITS-1:0];

  // S1 is tested first so it wins when both regions overlap.
  function automatic logic [2:0] decode(input logic [31-REGION_BITS:0] region);
    if (region == S1_BASE[31:REGION_BITS])      return 3'b001;
    else if (region == S2_BASE[31:REGION_BITS]) return 3'b010;
    else                                        return 3'b100;
  endfunction

`ifdef AXI_WR_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    mid_d   = mid_q;
    sel_d   = sel_q;
`ifdef AXI_WR_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (AWVALID_M0 || AWVALID_M1) begin
          grant_d = pick_m1 ? 2'b10 : 2'b01;
          mid_d   = pick_m1 ? 2'b10 : 2'b01;
          sel_d   = decode(req_region);
          state_d = S_AW;
`ifdef AXI_WR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_AW: if (AW_HS)     state_d = S_W;
      S_W:  if (W_LAST_HS) state_d = S_B;
      S_B: begin
        if (B_HS) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          mid_d   = 2'b00;
          sel_d   = 3'b000;
          prio_d  = grant_q[0];
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef AXI_WR_TIMEOUT_EN
    // A B_HS landing on the limit cycle is a normal completion, not a timeout.
    if (state_q != S_IDLE) begin
      cnt_d = cnt_q + 1'b1;
      if ((cnt_q == CNT_LIMIT) && !((state_q == S_B) && B_HS)) begin
        state_d = S_IDLE;
        grant_d = 2'b00;
        mid_d   = 2'b00;
        sel_d   = 3'b000;
        prio_d  = grant_q[0];
        tmo_d   = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      grant_q <= 2'b00;
      mid_q   <= 2'b00;
      sel_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      mid_q   <= mid_d;
      sel_q   <= sel_d;
    end
  end

`ifdef AXI_WR_TIMEOUT_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign TIMEOUT = tmo_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  assign GRANT     = grant_q;
  assign MASTER_ID = mid_q;
  assign SLAVE_SEL = sel_q;
  assign AW_EN     = (state_q == S_AW);
  assign W_EN      = (state_q == S_W);
  assign B_EN      = (state_q == S_B);
  assign BUSY      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_wr_sched
// Brief   : Self-checking bench for axi_wr_sched (vector table + scoreboard).
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_wr_sched;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        AWVALID_M0 = 1'b0, AWVALID_M1 = 1'b0;
  logic [31:0] AWADDR_M0 = '0, AWADDR_M1 = '0;
  logic        AW_HS = 1'b0, W_LAST_HS = 1'b0, B_HS = 1'b0;
  logic [1:0]  GRANT, MASTER_ID;
  logic [2:0]  SLAVE_SEL;
  logic        AW_EN, W_EN, B_EN, BUSY, TIMEOUT;

  axi_wr_sched #(
    .S1_BASE(32'h0000_0000), .S2_BASE(32'h0001_0000),
    .REGION_BITS(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID_M0(AWVALID_M0), .AWADDR_M0(AWADDR_M0),
    .AWVALID_M1(AWVALID_M1), .AWADDR_M1(AWADDR_M1),
    .AW_HS(AW_HS), .W_LAST_HS(W_LAST_HS), .B_HS(B_HS),
    .GRANT(GRANT), .MASTER_ID(MASTER_ID), .SLAVE_SEL(SLAVE_SEL),
    .AW_EN(AW_EN), .W_EN(W_EN), .B_EN(B_EN), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic        v1;
    logic [31:0] a1;
    logic [1:0]  grant;
    logic [2:0]  sel;
  } vec_t;

  typedef struct {
    logic [1:0] grant;
    logic [1:0] mid;
    logic [2:0] sel;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] g, input logic [2:0] s);
    exp_t e;
    e.grant = g;
    e.mid   = g;   // ID extension codes coincide with the one-hot grant
    e.sel   = s;
    sbq.push_back(e);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"}, BUSY, 0);
    chk({name, "_outs"}, {GRANT, MASTER_ID, SLAVE_SEL, AW_EN, W_EN, B_EN, TIMEOUT}, 0);
  endtask

  // Waits (bounded) for AW_EN, then compares the grant against the scoreboard.
  task automatic wait_grant(input string name);
    int   n = 0;
    exp_t e;
    while (!AW_EN && n < 4) begin
      step();
      n++;
    end
    chk({name, "_latency"}, n, 1);
    if (sbq.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sbq.pop_front();
      chk({name, "_grant"}, GRANT, e.grant);
      chk({name, "_mid"}, MASTER_ID, e.mid);
      chk({name, "_sel"}, SLAVE_SEL, e.sel);
    end
  endtask

  task automatic finish_txn(input string name);
    AW_HS = 1'b1;
    step();
    AW_HS = 1'b0;
    chk({name, "_w_en"}, W_EN, 1);
    W_LAST_HS = 1'b1;
    step();
    W_LAST_HS = 1'b0;
    chk({name, "_b_en"}, B_EN, 1);
    B_HS = 1'b1;
    step();
    B_HS = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string nm;
    logic [1:0] g;
    nm = $sformatf("vec%0d", i);
    AWVALID_M0 = v.v0; AWADDR_M0 = v.a0;
    AWVALID_M1 = v.v1; AWADDR_M1 = v.a1;
    push_exp(v.grant, v.sel);
    wait_grant(nm);
    g = GRANT;
    W_LAST_HS = 1'b1; B_HS = 1'b1;
    step();
    W_LAST_HS = 1'b0; B_HS = 1'b0;
    chk({nm, "_aw_ignore"}, {AW_EN, W_EN, B_EN}, 3'b100);
    AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0;
    step();
    chk({nm, "_aw_hold"}, AW_EN, 1);
    AW_HS = 1'b1;
    step();
    AW_HS = 1'b0;
    AWVALID_M0 = 1'b1; AWVALID_M1 = 1'b1; B_HS = 1'b1;
    step();
    AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0; B_HS = 1'b0;
    chk({nm, "_w_stay"}, {AW_EN, W_EN, B_EN}, 3'b010);
    chk({nm, "_grant_stable"}, GRANT, g);
    W_LAST_HS = 1'b1;
    step();
    W_LAST_HS = 1'b0;
    chk({nm, "_b_en"}, {AW_EN, W_EN, B_EN}, 3'b001);
    B_HS = 1'b1;
    step();
    B_HS = 1'b0;
    chk_idle({nm, "_done"});
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0001_0004, 2'b10, 3'b010};
    vecs[1] = '{1'b1, 32'h0000_0010, 1'b1, 32'h8000_0000, 2'b01, 3'b001};
    vecs[2] = '{1'b1, 32'h0000_0020, 1'b1, 32'h8000_0000, 2'b10, 3'b100};
    vecs[3] = '{1'b1, 32'h0001_FFFC, 1'b1, 32'h0000_0000, 2'b01, 3'b010};
    vecs[4] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0000_0000, 2'b01, 3'b100};
    vecs[5] = '{1'b1, 32'h0000_0010, 1'b0, 32'h0001_0000, 2'b01, 3'b001};
    vecs[6] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0002_0000, 2'b10, 3'b100};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_FFFF, 2'b01, 3'b100};
    vecs[8] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_FFFF, 2'b10, 3'b001};

    step();
    step();
    chk_idle("reset");
    #2 ARESET = 1'b0;
    step();
    chk_idle("post_reset");

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Simultaneous requests from reset: M0, then M1, then M0 again.
    #2 ARESET = 1'b1;
    #2 ARESET = 1'b0;
    step();
    AWVALID_M0 = 1'b1; AWADDR_M0 = 32'h0000_0100;
    AWVALID_M1 = 1'b1; AWADDR_M1 = 32'h0001_0100;
    push_exp(2'b01, 3'b001);
    wait_grant("b2b_first");
    finish_txn("b2b_first");
    chk("b2b_idle_after_bhs", BUSY, 0);
    push_exp(2'b10, 3'b010);
    wait_grant("b2b_second");
    finish_txn("b2b_second");
    chk("b2b_idle2", BUSY, 0);
    push_exp(2'b01, 3'b001);
    wait_grant("b2b_third");
    AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0;
    finish_txn("b2b_third");
    chk_idle("b2b_done");

    // Asynchronous abort mid-W, then a lone M1 request after release.
    AWVALID_M0 = 1'b1; AWADDR_M0 = 32'h0000_0040;
    push_exp(2'b01, 3'b001);
    wait_grant("abort_pre");
    AW_HS = 1'b1;
    step();
    AW_HS = 1'b0;
    AWVALID_M0 = 1'b0;
    chk("abort_in_w", W_EN, 1);
    AWVALID_M1 = 1'b1; AWADDR_M1 = 32'h0001_0008;
    #2 ARESET = 1'b1;
    #1 chk_idle("abort_async");
    #1 ARESET = 1'b0;
    push_exp(2'b10, 3'b010);
    wait_grant("abort_regrant");
    AWVALID_M1 = 1'b0;
    finish_txn("abort_regrant");
    chk_idle("abort_done");

`ifdef AXI_WR_TIMEOUT_EN
    AWVALID_M0 = 1'b1; AWADDR_M0 = 32'h0000_0000;
    push_exp(2'b01, 3'b001);
    wait_grant("tmo");
    AWVALID_M0 = 1'b0;
    AW_HS = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      AW_HS = 1'b0;
      chk($sformatf("tmo_wait%0d", k), {BUSY, TIMEOUT}, 2'b10);
    end
    step();
    chk("tmo_pulse", {BUSY, TIMEOUT}, 2'b01);
    step();
    chk_idle("tmo_after");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
